controlador_contador: RTL and testbench

CONTROLADOR_CONTADOR -- requirements
Module: controlador_contador

---
 rtl/controlador_contador_pkg.sv | 19 +
 rtl/controlador_contador.sv | 102 ++++++++++
 tb/tb_controlador_contador.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/controlador_contador_pkg.sv
// rtl/controlador_contador_pkg.sv - shared state encodings and types for controlador_contador
package controlador_contador_pkg;

  // FSM encodings, shared by the design and its bench
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Mode values as sampled with Start
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/controlador_contador.sv
// rtl/controlador_contador.sv - falling-edge period counter with one-shot/periodic modes
module controlador_contador
  import controlador_contador_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            NEclk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stop,
  input  logic            Pause,
  input  logic            Mode,
  input  logic [BITS-1:0] Period,
  output logic [BITS-1:0] count,
  output logic            Tick,
  output logic            Done,
  output logic            Busy
);

  localparam logic [BITS-1:0] ONE  = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0] ZERO = '0;

  state_t          state, state_n;
  logic [BITS-1:0] count_n;
  logic [BITS-1:0] period_q, period_n;
  logic            mode_q, mode_n;
  logic            tick_n, done_n;
  logic            last;

  // Terminal count; period_q is never zero while in RUN, so no underflow matters
  assign last = (count == (period_q - ONE));

  // Busy comes from the registered state only
  assign Busy = (state == S_RUN);

  // State and output registers, updated on the falling edge
  always_ff @(negedge NEclk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      count    <= ZERO;
      period_q <= ZERO;
      mode_q   <= MODE_ONESHOT;
      Tick     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      period_q <= period_n;
      mode_q   <= mode_n;
      Tick     <= tick_n;
      Done     <= done_n;
    end
  end

  // Next-state logic: Stop beats Start, Start beats Pause; Start with Period==0 is ignored
  always_comb begin
    state_n  = state;
    count_n  = count;
    period_n = period_q;
    mode_n   = mode_q;
    tick_n   = 1'b0;
    done_n   = Done;
    if (Stop) begin
      state_n = S_IDLE;
      count_n = ZERO;
      done_n  = 1'b0;
    end else if (Start && (Period != ZERO)) begin
      state_n  = S_RUN;
      count_n  = ZERO;
      period_n = Period;
      mode_n   = Mode;
      done_n   = 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (!Pause) begin
            if (last) begin
              tick_n = 1'b1;
              if (mode_q == MODE_PERIODIC) begin
                count_n = ZERO;
              end else begin
                done_n  = 1'b1;
                state_n = S_DONE;
              end
            end else begin
              count_n = count + ONE;
            end
          end
        end
        S_IDLE, S_DONE: begin
          // hold everything; Tick stays low
        end
        default: begin
          state_n = S_IDLE;
          count_n = ZERO;
          done_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_contador.sv
// tb/tb_controlador_contador.sv - scoreboard bench for controlador_contador
module tb_controlador_contador;
  import controlador_contador_pkg::*;

  localparam int BITS = 8;

  logic            NEclk;
  logic            Reset;
  logic            Start;
  logic            Stop;
  logic            Pause;
  logic            Mode;
  logic [BITS-1:0] Period;
  logic [BITS-1:0] count;
  logic            Tick;
  logic            Done;
  logic            Busy;

  typedef struct {
    logic [BITS-1:0] c;
    logic            t;
    logic            d;
    logic            b;
    string           nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  controlador_contador #(.BITS(BITS)) dut (
    .NEclk (NEclk),
    .Reset (Reset),
    .Start (Start),
    .Stop  (Stop),
    .Pause (Pause),
    .Mode  (Mode),
    .Period(Period),
    .count (count),
    .Tick  (Tick),
    .Done  (Done),
    .Busy  (Busy)
  );

  initial NEclk = 1'b1;
  always #5 NEclk = ~NEclk;

  // One active edge: expectation is what the outputs must show after it
  task automatic cyc(input logic [BITS-1:0] c, input logic t, input logic d,
                     input logic b, input string nm);
    exp_t e;
    @(negedge NEclk);
    #1;
    e.c = c; e.t = t; e.d = d; e.b = b; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Immediate comparison for checks that fall between active edges
  task automatic dchk(input string nm, input logic [BITS-1:0] c, input logic t,
                      input logic d, input logic b);
    n_checks++;
    if ({count, Tick, Done, Busy} !== {c, t, d, b}) begin
      n_fail++;
      $display("FAIL %s: got count=%0d tick=%0b done=%0b busy=%0b, expected count=%0d tick=%0b done=%0b busy=%0b",
               nm, count, Tick, Done, Busy, c, t, d, b);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampling on the inactive edge
  initial begin
    exp_t e;
    forever begin
      @(posedge NEclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({count, Tick, Done, Busy} !== {e.c, e.t, e.d, e.b}) begin
          n_fail++;
          $display("FAIL %s: got count=%0d tick=%0b done=%0b busy=%0b, expected count=%0d tick=%0b done=%0b busy=%0b",
                   e.nm, count, Tick, Done, Busy, e.c, e.t, e.d, e.b);
        end
      end
    end
  end

  task automatic do_stop();
    Stop = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b0, "stop");
    Stop = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Pause = 1'b0; Mode = 1'b0; Period = '0;
    repeat (2) @(negedge NEclk);
    #1;
    dchk("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dut.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_fsm_state: got %0d, expected %0d", dut.state, ST_IDLE);
    end
    Reset = 1'b0;
    cyc(8'd0, 1'b0, 1'b0, 1'b0, "idle_after_reset");
    Pause = 1'b1; Period = 8'd4;
    cyc(8'd0, 1'b0, 1'b0, 1'b0, "idle_ignores_pause");
    Pause = 1'b0;

    // Periodic P=5
    Period = 8'd5; Mode = 1'b1; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "p5_start");
    Start = 1'b0;
    for (int k = 1; k <= 10; k++)
      cyc(8'(k % 5), (k % 5) == 0, 1'b0, 1'b1, "p5_run");
    do_stop();

    // One-shot P=3
    Period = 8'd3; Mode = 1'b0; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "os3_start");
    Start = 1'b0;
    cyc(8'd1, 1'b0, 1'b0, 1'b1, "os3_c1");
    cyc(8'd2, 1'b0, 1'b0, 1'b1, "os3_c2");
    cyc(8'd2, 1'b1, 1'b1, 1'b0, "os3_done");
    Pause = 1'b1;
    cyc(8'd2, 1'b0, 1'b1, 1'b0, "os3_hold1");
    cyc(8'd2, 1'b0, 1'b1, 1'b0, "os3_hold2");
    Pause = 1'b0; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "os3_restart");
    Start = 1'b0;
    do_stop();

    // Pause at count 2, P=5 periodic: first Tick two cycles late
    Period = 8'd5; Mode = 1'b1; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "pause_start");
    Start = 1'b0;
    cyc(8'd1, 1'b0, 1'b0, 1'b1, "pause_c1");
    cyc(8'd2, 1'b0, 1'b0, 1'b1, "pause_c2");
    Pause = 1'b1;
    cyc(8'd2, 1'b0, 1'b0, 1'b1, "pause_hold1");
    cyc(8'd2, 1'b0, 1'b0, 1'b1, "pause_hold2");
    Pause = 1'b0;
    cyc(8'd3, 1'b0, 1'b0, 1'b1, "pause_c3");
    cyc(8'd4, 1'b0, 1'b0, 1'b1, "pause_c4");
    cyc(8'd0, 1'b1, 1'b0, 1'b1, "pause_tick");
    do_stop();

    // Asynchronous reset mid-run at count 3, P=10
    Period = 8'd10; Mode = 1'b1; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "rst_start");
    Start = 1'b0;
    for (int k = 1; k <= 3; k++)
      cyc(8'(k), 1'b0, 1'b0, 1'b1, "rst_run");
    @(posedge NEclk);
    #1 Reset = 1'b1;
    #1 dchk("reset_midrun", 8'd0, 1'b0, 1'b0, 1'b0);
    #1 Reset = 1'b0;
    cyc(8'd0, 1'b0, 1'b0, 1'b0, "rst_idle");

    // Priority and edge cases
    Period = 8'd10; Mode = 1'b1; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "prio_start");
    Start = 1'b0;
    cyc(8'd1, 1'b0, 1'b0, 1'b1, "prio_c1");
    Stop = 1'b1; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b0, "stop_beats_start");
    Stop = 1'b0; Start = 1'b1; Period = 8'd0;
    cyc(8'd0, 1'b0, 1'b0, 1'b0, "start_p0_ignored");
    Period = 8'd10;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "p10_start");
    Start = 1'b0;
    for (int k = 1; k <= 7; k++)
      cyc(8'(k), 1'b0, 1'b0, 1'b1, "p10_run");
    Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "restart_at7");
    Start = 1'b0; Period = 8'd3; Mode = 1'b0;
    for (int k = 1; k <= 9; k++)
      cyc(8'(k), 1'b0, 1'b0, 1'b1, "ignore_period_change");
    cyc(8'd0, 1'b1, 1'b0, 1'b1, "latched_periodic_wrap");
    do_stop();

    // P=1 periodic and one-shot
    Period = 8'd1; Mode = 1'b1; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "p1_start");
    Start = 1'b0;
    for (int k = 0; k < 4; k++)
      cyc(8'd0, 1'b1, 1'b0, 1'b1, "p1_tick_every_edge");
    Mode = 1'b0; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "p1_os_start");
    Start = 1'b0;
    cyc(8'd0, 1'b1, 1'b1, 1'b0, "p1_os_done");
    do_stop();

    // P=255 periodic
    Period = 8'd255; Mode = 1'b1; Start = 1'b1;
    cyc(8'd0, 1'b0, 1'b0, 1'b1, "p255_start");
    Start = 1'b0;
    for (int k = 1; k <= 510; k++)
      cyc(8'(k % 255), (k % 255) == 0, 1'b0, 1'b1, "p255_run");
    do_stop();

    repeat (4) @(posedge NEclk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
